// File: rtl/i_softmax_norm.sv
// i_softmax_norm: integer softmax normalisation stage.
// Buffers one row of non-negative exponential values, accumulates their sum,
// then emits floor(q_i * 2^OUT_BITS / sum) per element using a bit-serial
// restoring divider (OUT_BITS+1 iterations per element).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the producer side (out_valid,
// out_p, out_last) holds stable until the transfer completes.
module i_softmax_norm #(
    parameter int Q_WIDTH  = 32,
    parameter int S_WIDTH  = 16,
    parameter int ROW_LEN  = 8,
    parameter int OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [Q_WIDTH-1:0]  in_q,
    input  logic [S_WIDTH-1:0]  in_S,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS:0]   out_p,
    output logic                out_last,
    output logic                s_mismatch,
    output logic [1:0]          dbg_state
);

    localparam int EW   = Q_WIDTH - 1;            // clamped element width
    localparam int IW   = $clog2(ROW_LEN);        // row index width
    localparam int SUMW = EW + IW;                // sum width, cannot overflow
    localparam int RW   = SUMW + 1;               // remainder width
    localparam int BW   = $clog2(OUT_BITS + 1);   // quotient bit counter width
    localparam logic [IW-1:0] LAST_IDX = IW'(ROW_LEN - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        INIT = 2'd1,
        ITER = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [EW-1:0]      elem_buf [ROW_LEN];
    logic [SUMW-1:0]    sum;
    logic [RW-1:0]      rem;
    logic [OUT_BITS:0]  quot;
    logic [BW-1:0]      bitcnt;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      elem;
    logic [S_WIDTH-1:0] s_ref;

    logic               in_hs;
    logic               out_hs;
    logic [EW-1:0]      in_val;
    logic               sum_nz;
    logic               ge;
    logic [RW-1:0]      rem_sub;

    // Negative exponentials are clamped to zero; the sign bit is then dropped.
    assign in_val   = in_q[Q_WIDTH-1] ? '0 : in_q[Q_WIDTH-2:0];
    assign in_ready = (state == LOAD) && !rst;
    assign in_hs    = in_valid && in_ready;
    assign out_valid = (state == EMIT);
    assign out_hs   = out_valid && out_ready;
    assign out_p    = (state == EMIT) ? quot : '0;
    assign out_last = (state == EMIT) && (elem == LAST_IDX);
    assign dbg_state = state;

    // A zero row would make every compare succeed; gating on sum_nz keeps
    // the quotient at zero so no division by zero is ever attempted.
    assign sum_nz  = (sum != '0);
    assign ge      = (rem >= {1'b0, sum});
    assign rem_sub = ge ? (rem - {1'b0, sum}) : rem;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            LOAD: if (in_hs && idx == LAST_IDX) state_n = INIT;
            INIT: state_n = ITER;
            ITER: if (bitcnt == '0) state_n = EMIT;
            EMIT: if (out_hs) state_n = (elem == LAST_IDX) ? LOAD : INIT;
            default: state_n = LOAD;
        endcase
    end

    // Element buffer write; contents are only read after a full row is stored.
    always_ff @(posedge clk) begin
        if (in_hs) elem_buf[idx] <= in_val;
    end

    // Accumulation, scale consistency tracking and divider datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum        <= '0;
            rem        <= '0;
            quot       <= '0;
            bitcnt     <= '0;
            idx        <= '0;
            elem       <= '0;
            s_ref      <= '0;
            s_mismatch <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_hs) begin
                        sum <= sum + {{IW{1'b0}}, in_val};
                        if (idx == '0) begin
                            s_ref      <= in_S;
                            s_mismatch <= 1'b0;
                        end else if (in_S != s_ref) begin
                            s_mismatch <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            idx  <= '0;
                            elem <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                INIT: begin
                    rem    <= {{(RW-EW){1'b0}}, elem_buf[elem]};
                    quot   <= '0;
                    bitcnt <= BW'(OUT_BITS);
                end
                ITER: begin
                    quot   <= {quot[OUT_BITS-1:0], ge && sum_nz};
                    rem    <= rem_sub << 1;
                    bitcnt <= bitcnt - BW'(1);
                end
                EMIT: begin
                    if (out_hs) begin
                        if (elem == LAST_IDX) begin
                            sum <= '0;
                            idx <= '0;
                        end else begin
                            elem <= elem + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i_softmax_norm.sv
// Testbench for i_softmax_norm: directed table rows, back-pressure, resets
// mid-row and mid-output, and random rows checked against a ratio model.
module tb_i_softmax_norm;

    localparam int QW = 32;
    localparam int SW = 16;
    localparam int RL = 8;
    localparam int OB = 8;
    localparam int PW = OB + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [QW-1:0] in_q;
    logic [SW-1:0]        in_S;
    logic                 out_valid;
    logic                 out_ready;
    logic [OB:0]          out_p;
    logic                 out_last;
    logic                 s_mismatch;
    logic [1:0]           dbg_state;

    i_softmax_norm #(.Q_WIDTH(QW), .S_WIDTH(SW), .ROW_LEN(RL), .OUT_BITS(OB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_S(in_S),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_last(out_last), .s_mismatch(s_mismatch), .dbg_state(dbg_state)
    );

    typedef struct {
        logic signed [QW-1:0] q [RL];
        logic [SW-1:0]        s [RL];
        logic [OB:0]          p [RL];
        logic                 mm;
    } vec_t;

    vec_t        vt [6];
    vec_t        rv;
    logic [OB:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: p_i = floor(max(q_i,0) * 2^OB / sum), 0 for an all-zero row;
    // mismatch flag = any scale differs from the first one.
    function automatic void build_expected(inout vec_t v);
        longint c [RL];
        longint sum;
        sum = 0;
        for (int i = 0; i < RL; i++) begin
            c[i] = (v.q[i] < 0) ? 0 : longint'(v.q[i]);
            sum += c[i];
        end
        for (int i = 0; i < RL; i++)
            v.p[i] = (sum == 0) ? '0 : PW'((c[i] << OB) / sum);
        v.mm = 1'b0;
        for (int i = 1; i < RL; i++)
            if (v.s[i] != v.s[0]) v.mm = 1'b1;
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_elem(input logic signed [QW-1:0] q, input logic [SW-1:0] s);
        int g;
        in_valid = 1'b1;
        in_q     = q;
        in_S     = s;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_row(input vec_t v, input bit lat_chk);
        int n;
        for (int i = 0; i < RL; i++) send_elem(v.q[i], v.s[i]);
        check("s_mismatch_row", s_mismatch, v.mm);
        if (lat_chk) begin
            // Last handshake at edge t: INIT in cycle t+1, ITER from t+2,
            // out_valid in cycle t+OB+3, i.e. OB+2 edges after edge t.
            check("state_init", dbg_state, 1);
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
                if (n == 1) check("state_iter", dbg_state, 2);
            end
            check("first_out_latency", n, OB + 2);
        end
    endtask

    task automatic collect_row(input vec_t v, input bit stall);
        int          g;
        logic [OB:0] hold_p;
        logic        hold_l;
        logic [OB:0] e;
        for (int i = 0; i < RL; i++) exp_q.push_back(v.p[i]);
        for (int k = 0; k < RL; k++) begin
            g = 0;
            while (!out_valid && g < 100) begin
                check("in_ready_busy", in_ready, 0);
                @(negedge clk);
                g++;
            end
            if (g >= 100) begin
                check("out_valid_timeout", 0, 1);
                break;
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            hold_p = out_p;
            hold_l = out_last;
            g = 0;
            while (!out_ready) begin
                @(negedge clk);
                g++;
                check("stall_valid", out_valid, 1);
                check("stall_p", out_p, hold_p);
                check("stall_last", out_last, hold_l);
                check("stall_in_ready", in_ready, 0);
                out_ready = (g > 20) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            e = exp_q.pop_front();
            check("out_p", out_p, e);
            check("out_last", out_last, (k == RL - 1));
            @(negedge clk);
            out_ready = 1'b0;
            if (k < RL - 1) begin
                check("no_duplicate", out_valid, 0);
                check("in_ready_busy", in_ready, 0);
            end
        end
        check("in_ready_after_row", in_ready, 1);
        check("s_mismatch_held", s_mismatch, v.mm);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_p"}, out_p, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_s_mismatch"}, s_mismatch, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_q = '0; in_S = '0; out_ready = 1'b0;

        vt[0].q = '{1, 1, 1, 1, 1, 1, 1, 1};
        vt[0].s = '{3, 3, 3, 3, 3, 3, 3, 3};
        vt[0].p = '{32, 32, 32, 32, 32, 32, 32, 32};
        vt[0].mm = 1'b0;
        vt[1].q = '{1, 2, 3, 4, 5, 6, 7, 8};
        vt[1].s = '{7, 7, 7, 7, 7, 7, 7, 7};
        vt[1].p = '{7, 14, 21, 28, 35, 42, 49, 56};
        vt[1].mm = 1'b0;
        vt[2].q = '{256, 0, 0, 0, 0, 0, 0, 0};
        vt[2].s = '{1, 1, 1, 1, 1, 1, 1, 1};
        vt[2].p = '{256, 0, 0, 0, 0, 0, 0, 0};
        vt[2].mm = 1'b0;
        vt[3].q = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[3].s = '{2, 2, 2, 2, 2, 2, 2, 2};
        vt[3].p = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[3].mm = 1'b0;
        vt[4].q = '{1, 1, 1, 1, 1, -5, 1, 1};
        vt[4].s = '{4, 4, 4, 9, 4, 4, 4, 4};
        vt[4].p = '{36, 36, 36, 36, 36, 0, 36, 36};
        vt[4].mm = 1'b1;
        vt[5].q = '{1, 1, 1, 1, 1, 1, 1, 1};
        vt[5].s = '{4, 4, 4, 4, 4, 4, 4, 4};
        vt[5].p = '{32, 32, 32, 32, 32, 32, 32, 32};
        vt[5].mm = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_out_of_reset", in_ready, 1);

        // Directed rows, out_ready held high.
        for (int i = 0; i < 6; i++) begin
            send_row(vt[i], (i == 0));
            collect_row(vt[i], 1'b0);
        end

        // Random back-pressure on a known row.
        send_row(vt[1], 1'b0);
        collect_row(vt[1], 1'b1);

        // Reset after four inputs, with a scale mismatch already flagged.
        send_elem(10, 5);
        send_elem(20, 5);
        send_elem(30, 6);
        send_elem(40, 5);
        check("partial_mismatch", s_mismatch, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrow_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_row(vt[0], 1'b1);
        collect_row(vt[0], 1'b0);

        // Reset while an output is being presented.
        send_row(vt[1], 1'b0);
        begin
            int g;
            g = 0;
            while (!out_valid && g < 50) begin
                @(negedge clk);
                g++;
            end
            check("pre_reset_out_valid", out_valid, 1);
        end
        #2 rst = 1'b1;
        #1 check_reset_outputs("emit_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_row(vt[0], 1'b0);
        collect_row(vt[0], 1'b0);

        // Random rows against the reference model.
        for (int r = 0; r < 24; r++) begin
            int mode;
            logic [SW-1:0] base;
            mode = $urandom_range(0, 2);
            base = SW'($urandom_range(0, 65535));
            for (int i = 0; i < RL; i++) begin
                if (mode == 0)      rv.q[i] = QW'($urandom_range(0, 1000));
                else if (mode == 1) rv.q[i] = QW'($urandom() & 32'h7fff_ffff);
                else                rv.q[i] = QW'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) rv.q[i] = -QW'($urandom_range(1, 1000));
                rv.s[i] = ($urandom_range(0, 15) == 0) ? base + SW'(1) : base;
            end
            build_expected(rv);
            send_row(rv, 1'b0);
            collect_row(rv, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
